// File: rtl/exp_range_reduce.sv
`default_nettype none
//------------------------------------------------------------------------------
// exp_range_reduce: splits x into k*ln2 + r (r as Q2.14 CORDIC angle), 3-stage
// valid/ready pipe. Optional macro EXP_RR_UFLOW_EN adds the out_zero underflow flag.
// Revision: 1.0
//------------------------------------------------------------------------------
module exp_range_reduce #(
   parameter int IN_W  = 16,
   parameter int ANG_W = 16,
   parameter int K_W   = 6,
   parameter int K_MIN = -15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_x,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ANG_W-1:0] out_angle,
   output logic [K_W-1:0]   out_k
`ifdef EXP_RR_UFLOW_EN
   ,
   output logic             out_zero
`endif
);

   localparam int P_W  = IN_W + 16;
   localparam int KX_W = P_W - 25;
   localparam int M_W  = IN_W + 4;

   localparam logic signed [15:0]    c_INV_LN2 = 16'sd23637;
   localparam logic signed [15:0]    c_LN2     = 16'sd11357;
   localparam logic signed [P_W-1:0] c_HALF    = P_W'(1 << 24);

   if (K_MIN >= 0 || K_MIN < -(1 << (K_W - 1))) begin : g_kmin_chk
      $error("K_MIN must be negative and representable in K_W bits");
   end

   logic                    en;
   logic                    v1_q, v2_q;
   logic signed [IN_W-1:0]  x1_q, x2_q;
   logic signed [P_W-1:0]   p1_q, p1_d;
   logic signed [KX_W-1:0]  k2_q, k2_d;
   logic signed [M_W-1:0]   m2_q, m2_d;
   logic signed [M_W-1:0]   r_full;
   logic [ANG_W-1:0]        ang_d;
   logic [K_W-1:0]          k_d;
`ifdef EXP_RR_UFLOW_EN
   logic                    zero_d;
`endif

   // The whole pipe advances or freezes as one; bubbles only vanish at the output.
   assign en       = ~out_valid | out_ready;
   assign in_ready = en;

   always_comb begin
      p1_d   = P_W'($signed(in_x)) * P_W'(c_INV_LN2);
      // Adding one half before the arithmetic shift gives round-half-up.
      k2_d   = KX_W'((p1_q + c_HALF) >>> 25);
      m2_d   = M_W'(k2_d) * M_W'(c_LN2);
      r_full = (M_W'(x2_q) <<< 3) - m2_q;
      ang_d  = ANG_W'(r_full);
      k_d    = K_W'(k2_q);
`ifdef EXP_RR_UFLOW_EN
      zero_d = (k2_q < KX_W'(K_MIN));
      if (zero_d) begin
         ang_d = '0;
         k_d   = K_W'(K_MIN);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q      <= 1'b0;
         x1_q      <= '0;
         p1_q      <= '0;
         v2_q      <= 1'b0;
         x2_q      <= '0;
         k2_q      <= '0;
         m2_q      <= '0;
         out_valid <= 1'b0;
         out_angle <= '0;
         out_k     <= '0;
`ifdef EXP_RR_UFLOW_EN
         out_zero  <= 1'b0;
`endif
      end else if (en) begin
         v1_q      <= in_valid;
         x1_q      <= in_x;
         p1_q      <= p1_d;
         v2_q      <= v1_q;
         x2_q      <= x1_q;
         k2_q      <= k2_d;
         m2_q      <= m2_d;
         out_valid <= v2_q;
         out_angle <= ang_d;
         out_k     <= k_d;
`ifdef EXP_RR_UFLOW_EN
         out_zero  <= zero_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_exp_range_reduce.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_exp_range_reduce: directed self-checking bench for exp_range_reduce.
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_exp_range_reduce;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_x;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_angle;
   logic [5:0]  out_k;
`ifdef EXP_RR_UFLOW_EN
   logic        out_zero;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // x, expected raw k, expected raw r (hand computed)
   int vx [15] = '{0, 2048, -2048, -32768, 32767, 4096, -4096, 1024, -1024,
                   709, 710, -709, -710, -21000, -22528};
   int vk [15] = '{0, 1, -1, -23, 23, 3, -3, 1, -1, 0, 1, 0, -1, -15, -16};
   int va [15] = '{0, 5027, -5027, -933, 925, -1303, 1303, -3165, 3165,
                   5672, -5677, -5672, 5677, 2355, 1488};

   exp_range_reduce dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_angle (out_angle),
      .out_k     (out_k)
`ifdef EXP_RR_UFLOW_EN
      ,
      .out_zero  (out_zero)
`endif
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] ek(int i);
`ifdef EXP_RR_UFLOW_EN
      if (vk[i] < -15) return 6'(-15);
`endif
      return 6'(vk[i]);
   endfunction

   function automatic logic [15:0] ea(int i);
`ifdef EXP_RR_UFLOW_EN
      if (vk[i] < -15) return 16'd0;
`endif
      return 16'(va[i]);
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
      cyc(); cyc();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      n_cmp++;
      if (out_angle !== 16'd0) begin n_err++; $display("FAIL reset_angle got=%0d exp=0", $signed(out_angle)); end
      n_cmp++;
      if (out_k !== 6'd0) begin n_err++; $display("FAIL reset_k got=%0d exp=0", $signed(out_k)); end
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef EXP_RR_UFLOW_EN
      n_cmp++;
      if (out_zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got=%b exp=0", out_zero); end
`endif
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_vectors();
      for (int i = 0; i < 15; i++) begin
         in_valid = 1'b1; in_x = 16'(vx[i]);
         cyc();
         in_valid = 1'b0;
         cyc();
         n_cmp++;
         if (out_valid !== 1'b0) begin n_err++; $display("FAIL vec_early idx=%0d got=%b exp=0", i, out_valid); end
         cyc();
         n_cmp++;
         if (out_valid !== 1'b1) begin n_err++; $display("FAIL vec_valid idx=%0d got=%b exp=1", i, out_valid); end
         n_cmp++;
         if (out_k !== ek(i)) begin n_err++; $display("FAIL vec_k idx=%0d got=%0d exp=%0d", i, $signed(out_k), $signed(ek(i))); end
         n_cmp++;
         if (out_angle !== ea(i)) begin n_err++; $display("FAIL vec_angle idx=%0d got=%0d exp=%0d", i, $signed(out_angle), $signed(ea(i))); end
`ifdef EXP_RR_UFLOW_EN
         n_cmp++;
         if (out_zero !== (vk[i] < -15)) begin n_err++; $display("FAIL vec_zero idx=%0d got=%b exp=%b", i, out_zero, (vk[i] < -15)); end
`endif
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int t = 0; t < 11; t++) begin
         in_valid = (t < 8);
         in_x     = (t < 8) ? 16'(vx[t]) : 16'd0;
         cyc();
         if (t >= 2 && t < 10) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_k !== ek(t - 2) || out_angle !== ea(t - 2)) begin
               n_err++;
               $display("FAIL b2b idx=%0d got v=%b k=%0d a=%0d exp v=1 k=%0d a=%0d", t - 2, out_valid,
                        $signed(out_k), $signed(out_angle), $signed(ek(t - 2)), $signed(ea(t - 2)));
            end
         end else if (t == 10) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_tail got=%b exp=0", out_valid); end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_stall();
      int          sent = 0;
      int          got  = 0;
      logic        stalled;
      logic        acc;
      logic [15:0] hold_a;
      logic [5:0]  hold_k;
      for (int t = 0; t < 40 && got < 5; t++) begin
         in_valid  = (sent < 5);
         in_x      = 16'(vx[2 + ((sent < 5) ? sent : 0)]);
         out_ready = !(t >= 4 && t < 8);
         #1;
         acc     = in_valid && in_ready;
         stalled = out_valid && !out_ready;
         hold_a  = out_angle;
         hold_k  = out_k;
         if (out_valid && out_ready) begin
            n_cmp++;
            if (out_k !== ek(2 + got) || out_angle !== ea(2 + got)) begin
               n_err++;
               $display("FAIL stall_data idx=%0d got k=%0d a=%0d exp k=%0d a=%0d", got,
                        $signed(out_k), $signed(out_angle), $signed(ek(2 + got)), $signed(ea(2 + got)));
            end
            got++;
         end
         if (stalled) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready t=%0d got=%b exp=0", t, in_ready); end
         end
         cyc();
         if (stalled) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_angle !== hold_a || out_k !== hold_k) begin
               n_err++;
               $display("FAIL stall_hold t=%0d got v=%b k=%0d a=%0d exp v=1 k=%0d a=%0d", t, out_valid,
                        $signed(out_k), $signed(out_angle), $signed(hold_k), $signed(hold_a));
            end
         end
         if (acc) sent++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_cmp++;
      if (got != 5) begin n_err++; $display("FAIL stall_count got=%0d exp=5", got); end
      for (int t = 0; t < 3; t++) begin
         cyc();
         n_cmp++;
         if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_dup t=%0d got=%b exp=0", t, out_valid); end
      end
   endtask

   task automatic test_reset_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_x = 16'(vx[5 + i]);
         cyc();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
      out_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         cyc();
         n_cmp++;
         if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_ghost t=%0d got=%b exp=0", t, out_valid); end
      end
      in_valid = 1'b1; in_x = 16'd2048;
      cyc();
      in_valid = 1'b0;
      cyc();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_early got=%b exp=0", out_valid); end
      cyc();
      n_cmp++;
      if (out_valid !== 1'b1 || out_k !== 6'd1 || out_angle !== 16'd5027) begin
         n_err++;
         $display("FAIL flush_new got v=%b k=%0d a=%0d exp v=1 k=1 a=5027", out_valid,
                  $signed(out_k), $signed(out_angle));
      end
      cyc();
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_stall();
      test_reset_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
